iob_fifo_wr_arbiter: RTL
========================

Name: iob_fifo_wr_arbiter

Overview:
- Shares the single write port of an iob_fifo_async instance among N_REQ requesters in the write clock domain.
- Grants round-robin, in bounded bursts.
- Admits a burst only when the FIFO has room for a full burst, so a granted burst never stalls on full.
- Sits between producer engines and the FIFO write port; runs on the FIFO write clock.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 32, word width; equals the FIFO W_DATA_W.
- ADDR_W, 6, FIFO ADDR_W; fifo_w_level width is ADDR_W+1.
- BURST_MAX, 8, maximum words per grant (1..2^ADDR_W).

Ports:
- clk  in  1  write-domain clock, same as FIFO w_clk.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  per-requester word accepted.
- gnt_id  out  $clog2(N_REQ)  registered index of the current or last grantee.
- busy  out  1  burst in progress.
- fifo_w_en  out  1  to FIFO w_en.
- fifo_w_data  out  DATA_W  to FIFO w_data.
- fifo_w_full  in  1  from FIFO w_full.
- fifo_w_level  in  ADDR_W+1  from FIFO w_level, in FIFO words (symmetric use).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, gnt_id=0, rr pointer=0, burst count=0, busy=0, req_ready=0, fifo_w_en=0.
- Reset mid-burst aborts the burst. No word is written in the reset cycle.
- Free space: free = 2^ADDR_W - fifo_w_level, computed at ADDR_W+1 bits.
  - The write-domain level is pessimistic, so free is safe.
- State IDLE:
  - Arbitrate when any req_valid=1, fifo_w_full=0 and free >= BURST_MAX.
  - Winner is the first valid index at or after the rr pointer, modulo N_REQ.
  - Next cycle: state=BURST, gnt_id=winner, count=0, busy=1.
  - Arbitration costs one idle cycle; the first word transfers the cycle after the grant.
- State BURST:
  - xfer = req_valid[gnt_id] & ~fifo_w_full.
  - fifo_w_en = xfer; req_ready[gnt_id] = xfer; all other req_ready=0.
  - fifo_w_data = req_data of gnt_id, combinational mux.
  - count increments on xfer.
- Burst ends (next state IDLE, rr pointer = gnt_id+1 mod N_REQ, busy=0) on any of:
  - xfer with count == BURST_MAX-1;
  - req_valid[gnt_id]=0 for one cycle (a gap ends the burst);
  - fifo_w_full=1. This is defensive only; a word presented with full=1 is not accepted.
- Requesters must not retract req_data while req_valid=1 and req_ready=0.
- In IDLE, all req_ready=0 and fifo_w_en=0. A burst never starts while the FIFO reports full, which covers the FIFO INIT cycle where full=1.
- A requester dropping valid forfeits the rest of its burst. Its next grant waits for its round-robin turn.
- Simultaneous burst end and new requests: the end cycle returns to IDLE. Re-arbitration uses the updated pointer in the IDLE cycle.
- Throughput: BURST_MAX words per BURST_MAX+1 cycles under continuous demand.

Optional Feature:
- IOB_FIFO_WR_ARB_PRIO_EN defined: requester 0 has strict priority at every arbitration point.
  - If req_valid[0]=1 it wins regardless of the rr pointer.
  - It never preempts a running burst.
  - The rr pointer advances only after bursts granted to requesters 1..N_REQ-1.
- Undefined: pure round-robin over all requesters.

Decomposition:
- Shared package/header iob_fifo_wr_arbiter.vh holds:
  - state encodings IDLE=0, BURST=1;
  - the count width localparam $clog2(BURST_MAX+1);
  - the gnt_id width $clog2(N_REQ).
- Sub-module iob_rr_arbiter (N parameter) holds the rr pointer register. Interface: req vector, enable, advance, grant one-hot/index outputs.
- The top module holds the burst FSM, the data mux and the admission check.

Test Plan:
- Reset then idle:
  - stimulus: no valids;
  - required: busy=0, fifo_w_en=0, req_ready=0, gnt_id=0 throughout.
- Single requester, 20 continuous words, BURST_MAX=8, empty FIFO:
  - required bursts of 8, 8, 4 words, each separated by one idle cycle;
  - data enters the FIFO in order;
  - the final level is 20.
- All 4 requesters valid continuously:
  - required grant order 0,1,2,3,0;
  - each grant delivers 8 words.
- Admission:
  - stimulus: preload FIFO level to 60 (ADDR_W=6, free=4 < 8), then assert req_valid[2];
  - required: no grant until a reader drains the level to <= 56, then an 8-word burst.
- Gap:
  - stimulus: requester 1 drops valid after 3 words while requester 2 waits;
  - required: burst ends after 3 words, next grant goes to 2, level +3.
- With IOB_FIFO_WR_ARB_PRIO_EN:
  - stimulus: requesters 0 and 3 valid, rr pointer=3;
  - required: requester 0 is granted first, then 3 gets a turn only after requester 0 drops valid.

Source files
------------

// File: rtl/iob_fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the iob_fifo_wr_arbiter slice.
// The optional IOB_FIFO_WR_ARB_PRIO_EN feature is implemented in the top module.
package iob_fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Burst counter must be able to hold BURST_MAX itself after the last word.
    function automatic int cnt_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_fifo_wr_arbiter_rr.sv
// Round-robin requester picker: first valid index at or after the rotating pointer.
// The pointer moves to one past the advancing grantee when i_advance is pulsed.
module iob_rr_arbiter
    import iob_fifo_wr_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    input  logic          i_advance,
    input  logic [IW-1:0] i_adv_idx,
    output logic [N-1:0]  o_gnt_oh,
    output logic [IW-1:0] o_gnt_idx
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_gnt_idx;
    logic          w_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (i_adv_idx == IW'(N - 1)) ? '0 : i_adv_idx + IW'(1);
        end
    end

    always_comb begin
        int w_idx;
        w_idx     = 0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = IW'(w_idx);
            end
        end
    end

    assign o_gnt_idx = w_gnt_idx;
    assign o_gnt_oh  = (i_en && w_found) ? (N'(1) << w_gnt_idx) : '0;

endmodule

// File: rtl/iob_fifo_wr_arbiter.sv
// Burst write-port arbiter sharing one iob_fifo_async write port among N_REQ requesters.
// Define IOB_FIFO_WR_ARB_PRIO_EN to give requester 0 strict priority at each arbitration.
module iob_fifo_wr_arbiter
    import iob_fifo_wr_arbiter_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 6,
    parameter  int BURST_MAX = 8,
    localparam int ID_W      = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [ID_W-1:0]         gnt_id,
    output logic                    busy,
    output logic                    fifo_w_en,
    output logic [DATA_W-1:0]       fifo_w_data,
    input  logic                    fifo_w_full,
    input  logic [ADDR_W:0]         fifo_w_level
);

    localparam int              CNT_W     = cnt_width(BURST_MAX);
    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] BURST_LIM = (ADDR_W + 1)'(BURST_MAX);

    state_t           r_state;
    state_t           w_next_state;
    logic [ID_W-1:0]  r_gnt_id;
    logic [CNT_W-1:0] r_count;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_rr_idx;
    logic [N_REQ-1:0] w_rr_oh;
    logic [ADDR_W:0]  w_free;
    logic             w_room;
    logic             w_admit;
    logic             w_sel_valid;
    logic             w_xfer;
    logic             w_last;
    logic             w_burst_end;
    logic             w_advance;

    // Only admit a burst when a full BURST_MAX words fit, so a granted burst never meets full.
    assign w_free  = DEPTH - fifo_w_level;
    assign w_room  = (r_state == IDLE) && !fifo_w_full && (w_free >= BURST_LIM);
    assign w_admit = |w_rr_oh;

    iob_rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req_valid),
        .i_en      (w_room),
        .i_advance (w_advance),
        .i_adv_idx (r_gnt_id),
        .o_gnt_oh  (w_rr_oh),
        .o_gnt_idx (w_rr_idx)
    );

`ifdef IOB_FIFO_WR_ARB_PRIO_EN
    assign w_winner  = req_valid[0] ? '0 : w_rr_idx;
    assign w_advance = w_burst_end && (r_gnt_id != '0);
`else
    assign w_winner  = w_rr_idx;
    assign w_advance = w_burst_end;
`endif

    always_comb begin
        w_sel_valid = 1'b0;
        fifo_w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt_id == ID_W'(i)) begin
                w_sel_valid = req_valid[i];
                fifo_w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A burst ends on its last word, on any valid gap, or defensively on full.
    assign w_xfer      = (r_state == BURST) && w_sel_valid && !fifo_w_full;
    assign w_last      = (r_count == CNT_W'(BURST_MAX - 1));
    assign w_burst_end = (r_state == BURST) && (!w_xfer || w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt_id <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_admit) begin
                r_gnt_id <= w_winner;
                r_count  <= '0;
            end else if (w_xfer) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_admit) begin
                    w_next_state = BURST;
                end
            end
            BURST: begin
                if (w_burst_end) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == BURST);
        fifo_w_en = w_xfer;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_xfer && (r_gnt_id == ID_W'(i));
        end
    end

    assign gnt_id = r_gnt_id;

endmodule
